// File: rtl/varint_decode_fsm_if.sv
// Handshake bundle between the varint decoder, its upstream byte FIFO and downstream word FIFO.
// master = decoder side, slave = FIFO/environment side.
interface varint_decode_fsm_if;
   logic        varint_in_fifo_empty;
   logic        varint_in_fifo_pop;
   logic [7:0]  varint_in;
   logic        varint_out_fifo_full;
   logic        varint_out_fifo_push;
   logic [31:0] varint_out;
   logic [2:0]  varint_out_len;
   logic        varint_err;
   logic [15:0] varint_err_cnt;

   modport master (
      input  varint_in_fifo_empty, varint_in, varint_out_fifo_full,
      output varint_in_fifo_pop, varint_out_fifo_push, varint_out,
             varint_out_len, varint_err, varint_err_cnt
   );

   modport slave (
      output varint_in_fifo_empty, varint_in, varint_out_fifo_full,
      input  varint_in_fifo_pop, varint_out_fifo_push, varint_out,
             varint_out_len, varint_err, varint_err_cnt
   );
endinterface

// File: rtl/varint_decode_fsm.sv
// Protobuf base-128 varint decoder: pops bytes from a show-ahead FIFO, pushes 32-bit words plus length.
// Optional malformed-varint detection/discard is built when VARINT_DECODE_ERR_EN is defined.
module varint_decode_fsm (
   input logic                 clk,
   input logic                 reset,
   varint_decode_fsm_if.master bus
);

   typedef enum logic [1:0] {
      ACCUM   = 2'd0,
      EMIT    = 2'd1,
      DISCARD = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] acc_q, acc_d;
   logic [2:0]  idx_q, idx_d;
   logic [2:0]  len_q, len_d;
   logic [7:0]  b;
   logic        pop, push, term, last;

`ifdef VARINT_DECODE_ERR_EN
   logic        err_q, err_d;
   logic [15:0] err_cnt_q, err_cnt_d;
   logic        bad;
`else
   // Set after a continuation bit on byte 4: payload bits are dropped until the terminator.
   logic        skip_q, skip_d;
`endif

   function automatic logic [31:0] merge_byte(input logic [31:0] acc,
                                              input logic [2:0]  idx,
                                              input logic [6:0]  bits);
      logic [31:0] r;
      r = acc;
      case (idx)
         3'd0:    r        = {25'd0, bits};
         3'd1:    r[13:7]  = bits;
         3'd2:    r[20:14] = bits;
         3'd3:    r[27:21] = bits;
         default: r[31:28] = bits[3:0];
      endcase
      return r;
   endfunction

   assign b    = bus.varint_in;
   assign term = ~b[7];
   assign last = (idx_q == 3'd4);
`ifdef VARINT_DECODE_ERR_EN
   assign bad  = last && ((b[6:4] != 3'b000) || b[7]);
`endif

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      idx_d   = idx_q;
      len_d   = len_q;
      pop     = 1'b0;
      push    = 1'b0;
`ifdef VARINT_DECODE_ERR_EN
      err_d     = 1'b0;
      err_cnt_d = err_cnt_q;
`else
      skip_d    = skip_q;
`endif
      case (state_q)
         ACCUM: begin
            pop = ~bus.varint_in_fifo_empty;
            if (pop) begin
`ifdef VARINT_DECODE_ERR_EN
               if (bad) begin
                  err_d = 1'b1;
                  if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
                  idx_d   = 3'd0;
                  state_d = b[7] ? DISCARD : ACCUM;
               end else begin
                  acc_d = merge_byte(acc_q, idx_q, b[6:0]);
                  if (term) begin
                     len_d   = idx_q + 3'd1;
                     state_d = EMIT;
                  end else begin
                     idx_d = idx_q + 3'd1;
                  end
               end
`else
               if (!skip_q) acc_d = merge_byte(acc_q, idx_q, b[6:0]);
               if (term) begin
                  len_d   = idx_q + 3'd1;
                  state_d = EMIT;
                  skip_d  = 1'b0;
               end else if (last) begin
                  skip_d = 1'b1;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
`endif
            end
         end
         EMIT: begin
            push = ~bus.varint_out_fifo_full;
            if (push) begin
               idx_d   = 3'd0;
               state_d = ACCUM;
            end
         end
`ifdef VARINT_DECODE_ERR_EN
         DISCARD: begin
            pop = ~bus.varint_in_fifo_empty;
            if (pop && term) begin
               idx_d   = 3'd0;
               state_d = ACCUM;
            end
         end
`endif
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ACCUM;
         acc_q   <= 32'd0;
         idx_q   <= 3'd0;
         len_q   <= 3'd0;
`ifdef VARINT_DECODE_ERR_EN
         err_q     <= 1'b0;
         err_cnt_q <= 16'd0;
`else
         skip_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
`ifdef VARINT_DECODE_ERR_EN
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
`else
         skip_q    <= skip_d;
`endif
      end
   end

   assign bus.varint_in_fifo_pop   = pop;
   assign bus.varint_out_fifo_push = push;
   assign bus.varint_out           = acc_q;
   assign bus.varint_out_len       = len_q;
`ifdef VARINT_DECODE_ERR_EN
   assign bus.varint_err           = err_q;
   assign bus.varint_err_cnt       = err_cnt_q;
`else
   assign bus.varint_err           = 1'b0;
   assign bus.varint_err_cnt       = 16'd0;
`endif

endmodule

// File: doc/varint_decode_fsm.md
# varint_decode_fsm

Control FSM and datapath for the protobuf varint decoder, the receive-side counterpart of the varint encoder. It pops little-endian base-128 varint bytes from an upstream show-ahead byte FIFO and reassembles each value into one 32-bit word. Each completed word is pushed into a downstream word FIFO together with its encoded byte length. It sits between the ingress byte stream and the field-extraction stage.

## Interface

Parameters:
- none; widths are fixed at 8-bit in and 32-bit out.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `varint_in_fifo_empty` in 1: byte FIFO empty.
- `varint_in_fifo_pop` out 1: pops the head byte at the next edge.
- `varint_in` in 8: head byte of the show-ahead FIFO; valid whenever empty=0.
- `varint_out_fifo_full` in 1: word FIFO full.
- `varint_out_fifo_push` out 1: writes `varint_out`/`varint_out_len` at the next edge.
- `varint_out` out 32: decoded value.
- `varint_out_len` out 3: encoded length, 1..5.
- `varint_err` out 1: one-cycle pulse on a malformed varint.
- `varint_err_cnt` out 16: saturating malformed-varint count.

## Operation

- States: ACCUM, EMIT, DISCARD. Reset state is ACCUM.
- Registers:
  - `acc[31:0]`
  - `idx[2:0]`: byte index 0..4
  - `len[2:0]`
- ACCUM:
  - `varint_in_fifo_pop = !varint_in_fifo_empty`; pop is combinational from state and empty.
  - On each popped byte b at index i (0..3): `acc[7i+6:7i] <= b[6:0]`.
    - At i=0, the remaining bits of `acc` are cleared.
  - At i=4: `acc[31:28] <= b[3:0]`.
  - If b[7]=0: `len <= i+1`, then go to EMIT.
  - Otherwise `idx` increments.
- EMIT:
  - `varint_out_fifo_push = !varint_out_fifo_full`.
  - `varint_out = acc`, `varint_out_len = len`.
  - No pop occurs in EMIT.
  - On the push edge: `idx <= 0`, return to ACCUM.
  - While full, stay in EMIT with outputs stable.
- DISCARD (only reachable with the macro):
  - Pop while not empty.
  - On a popped byte with b[7]=0, return to ACCUM with `idx=0`.
  - Nothing is pushed.
- Malformed varint, defined at i=4 as b[6:4]≠0 or b[7]=1.
  - Behaviour depends on the Configuration macro.
- Arithmetic:
  - Unsigned only; no zigzag.
  - Non-minimal encodings (e.g. 0x80 0x00 → 0, len 2) are legal and are not errors.
- Simultaneous events: an empty input in ACCUM holds all state; a full output in EMIT holds all state.

## Timing

- Reset values:
  - `varint_in_fifo_pop`, `varint_out_fifo_push`, `varint_err` = 0.
  - `varint_out` = 0, `varint_out_len` = 0, `varint_err_cnt` = 0.
  - `acc`, `idx`, `len` = 0.
  - State = ACCUM.
- Pop and push are combinational from registered state and FIFO flags. All other outputs are registered.
- Latency: the terminating byte is popped at edge N; push is asserted in cycle N+1 if not full.
- Throughput: one value per (len+1) cycles with no backpressure.
- A reset assertion mid-value drops the partial value.
  - No push or err occurs after reset deasserts.
  - The next byte is treated as i=0.

## Configuration

- Macro: `VARINT_DECODE_ERR_EN`.
- Defined, on a malformed byte:
  - `varint_err` is 1 in the cycle after the offending pop.
  - `varint_err_cnt` increments, saturating at 0xFFFF.
  - The partial value is discarded and never pushed.
  - If b[7]=1, go to DISCARD; otherwise return to ACCUM with `idx=0`.
- Undefined:
  - b[6:4] of byte 4 are ignored.
  - If b[7]=1 at i=4, subsequent bytes are popped and ignored until the terminator.
  - At the terminator, `acc` is pushed with len=5.
  - `varint_err` and `varint_err_cnt` are tied to 0.
  - DISCARD is not built.

## Test plan

- Bytes 0x01 → push `varint_out`=0x00000001, len=1, one cycle after the pop.
- Bytes 0xAC 0x02 → `varint_out`=300 (0x12C), len=2; 0x00 → 0, len=1.
- Bytes 0xFF 0xFF 0xFF 0xFF 0x0F → 0xFFFFFFFF, len=5.
- Backpressure:
  - Stimulus: bytes 0x96 0x01 with `varint_out_fifo_full`=1 for 3 cycles.
  - Response: push held low and `varint_out`=150 stable; push fires on the first cycle after full drops; no pop while in EMIT.
- Overlong input: 0x80×5 then 0x01, then 0x05.
  - With the macro: one `varint_err` pulse, `varint_err_cnt`=1, then a single push of 5.
  - Without the macro: push of 0 with len=5, then a push of 5.
- Reset mid-value: pop 0xFF 0xFF, assert `reset` low for 2 cycles, then 0x7F → single push of 0x7F, len=1.
